reorder_buffer: RTL
===================

# reorder_buffer

Circular in-order retirement buffer that sits between the decoder and the architectural state. It allocates ROB ids at issue and takes completion results from the reservation-station/ALU path and from the load-store buffer. It serves operand-forwarding queries for the decoder and retires one entry per cycle to the register file or the LSB. A committed branch mispredict or a JALR triggers a pipeline-wide flush with a redirect PC.

## Interface
- ROB_WIDTH, 3: id width; ROB_SIZE = 2^ROB_WIDTH entries.
- clk_in  in  1  clock.
- rst_n_in  in  1  reset, asynchronous, active-low.
- rdy_in  in  1  global enable; when low, all state holds.
- dec_full  out  1  high when count == ROB_SIZE.
- dec_rdy  in  1  issue request; the decoder asserts it only when dec_full is low.
- dec_type  in  2  0 REG, 1 STORE, 2 BRANCH, 3 JALR.
- dec_rd  in  5  destination register; used for REG and JALR.
- dec_pred_jump  in  1  predicted taken; used for BRANCH.
- dec_alt_pc  in  32  redirect PC if the BRANCH prediction is wrong.
- dec_value  in  32  prefilled rd value; JALR supplies pc+4.
- dec_rob_id  out  ROB_WIDTH  id allotted to the issuing instruction (= tail).
- rs_rdy, rs_rob_id, rs_data, rs_set_jump_addr  in  1/ROB_WIDTH/32/1  ALU completion.
- lsb_rdy, lsb_rob_id, lsb_data  in  1/ROB_WIDTH/32  load completion or store-ready.
- query_id_j, query_id_k  in  ROB_WIDTH  operand lookups.
- query_ready_j, query_ready_k  out  1  slot has a result (combinational).
- query_data_j, query_data_k  out  32  slot value (combinational).
- reg_en, reg_rd, reg_rob_id, reg_data  out  1/5/ROB_WIDTH/32  registered register-file commit.
- lsb_commit_en, lsb_commit_rob_id  out  1/ROB_WIDTH  registered store commit.
- flush  out  1  registered, one-cycle pulse.
- flush_pc  out  32  redirect PC, valid while flush is high.

## Operation
- Per-entry state:
  - present, ready, type, rd, pred_jump, value[31:0], addr[31:0].
  - Pointers head and tail (ROB_WIDTH bits, natural wrap) and count (ROB_WIDTH+1 bits).
- Issue (dec_rdy && !flush):
  - Write the slot at tail: present=1, ready=0, and the fields from the dec_* inputs.
  - For BRANCH, addr <= dec_alt_pc. For JALR, value <= dec_value.
  - tail++.
- Completion, RS port (rs_rdy && !flush), slot rs_rob_id:
  - If rs_set_jump_addr: addr <= rs_data.
  - Else: value <= rs_data.
  - In both cases ready <= 1.
- Completion, LSB port: value <= lsb_data; ready <= 1.
  - Both ports may write different slots in the same cycle.
  - If both target the same slot, RS wins.
  - A completion and an issue to the same slot in the same cycle is illegal.
- Query: the outputs reflect the stored ready/value of the slot.
  - This holds even after the slot commits, until the slot is reissued; issue clears ready.
  - Same-cycle completions are not forwarded.
- Commit: when the head slot is present and ready, exactly one commit per cycle.
  - REG: reg_en pulse with rd/value.
  - STORE: lsb_commit_en pulse.
  - BRANCH: if value[0] != pred_jump, set flush=1 and flush_pc=addr.
  - JALR: reg write of value, plus flush=1 with flush_pc=addr.
  - head++ and present <= 0.
- Flush entry (at the commit edge that raises flush):
  - Clear every present bit; head=tail=count=0. The commit outputs for that instruction still pulse.
  - While flush is high, ignore dec_rdy, rs_rdy and lsb_rdy.
  - No commit occurs in the flush cycle, because the buffer is empty.
- count += issue - commit; issue and commit may occur in the same cycle.

## Timing
- Reset (asynchronous, rst_n_in low): all pointers and flags are 0.
  - Outputs: reg_en=0, lsb_commit_en=0, flush=0, flush_pc=0, reg_rd=0, reg_data=0, reg_rob_id=0, lsb_commit_rob_id=0.
  - A reset mid-operation abandons all entries immediately.
- Issue at edge N: the slot is visible to queries and to the commit check from cycle N+1.
- Completion at edge N: earliest commit at edge N+1; commit outputs are valid in the following cycle. Completion to commit output is 2 cycles minimum.
- dec_full is combinational from count.
  - At count == ROB_SIZE, a same-cycle commit does not lower dec_full until the next cycle.
- A reg_en or lsb_commit_en pulse lasts exactly one cycle and is 0 in every cycle without a commit.
- rdy_in low: no pointer, flag or output register changes, and pulses are held.

## Test plan
- Reset:
  - Stimulus: drive rst_n_in low mid-issue.
  - Required response: immediately flush=0, reg_en=0, dec_full=0. First issue after release gets dec_rob_id=0.
- Out-of-order completion:
  - Stimulus: issue REG ids 0,1,2 with rd=1,2,3; complete 2, then 0, then 1 with data 0x30/0x10/0x20.
  - Required response: reg_en pulses in order rd1=0x10, rd2=0x20, rd3=0x30 on consecutive cycles after id1 completes.
- Full and wrap:
  - Stimulus: issue 8 entries.
  - Required response: dec_full=1.
  - Stimulus: complete id0.
  - Required response: dec_full drops the cycle after commit. Next issue gets id0 with tail wrapped, and its query_ready_j is 0.
- Mispredict:
  - Stimulus: BRANCH with pred=0, alt_pc=0x100, completed with data=1; younger REG entries pending.
  - Required response: flush=1 with flush_pc=0x100 for one cycle, younger entries never commit, count=0, next issue gets id0.
- JALR:
  - Stimulus: dec_value=0x1008, rd=1; rs_set_jump_addr=1 with data 0x2000.
  - Required response: reg_en with rd1=0x1008, and flush with flush_pc=0x2000.
- Dual completion and query:
  - Stimulus: RS and LSB complete ids 3 and 4 in the same cycle.
  - Required response: queries next cycle return ready=1 with the correct data for both ids.

Source files
------------

// File: rtl/reorder_buffer.sv
// reorder_buffer: circular in-order retirement buffer.
// Entries are allocated at the tail on issue, completed out of order by the
// RS/ALU port and the LSB port, and retired from the head one per cycle into
// registered commit outputs. A retiring mispredicted BRANCH or any JALR
// raises a one-cycle flush that empties the buffer and carries a redirect PC.
//
// Handshake: an issue is taken on a clock edge where rdy_in && dec_rdy are
// high, flush is low and dec_full is low; completions are taken on an edge
// where rdy_in && rs_rdy (or lsb_rdy) are high and flush is low. There is no
// back-pressure on completions or commits.
module reorder_buffer #(
  parameter int ROB_WIDTH = 3
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 rdy_in,
  // decoder issue
  output logic                 dec_full,
  input  logic                 dec_rdy,
  input  logic [1:0]           dec_type,
  input  logic [4:0]           dec_rd,
  input  logic                 dec_pred_jump,
  input  logic [31:0]          dec_alt_pc,
  input  logic [31:0]          dec_value,
  output logic [ROB_WIDTH-1:0] dec_rob_id,
  // RS/ALU completion
  input  logic                 rs_rdy,
  input  logic [ROB_WIDTH-1:0] rs_rob_id,
  input  logic [31:0]          rs_data,
  input  logic                 rs_set_jump_addr,
  // LSB completion
  input  logic                 lsb_rdy,
  input  logic [ROB_WIDTH-1:0] lsb_rob_id,
  input  logic [31:0]          lsb_data,
  // operand queries
  input  logic [ROB_WIDTH-1:0] query_id_j,
  input  logic [ROB_WIDTH-1:0] query_id_k,
  output logic                 query_ready_j,
  output logic                 query_ready_k,
  output logic [31:0]          query_data_j,
  output logic [31:0]          query_data_k,
  // register-file commit
  output logic                 reg_en,
  output logic [4:0]           reg_rd,
  output logic [ROB_WIDTH-1:0] reg_rob_id,
  output logic [31:0]          reg_data,
  // store commit
  output logic                 lsb_commit_en,
  output logic [ROB_WIDTH-1:0] lsb_commit_rob_id,
  // pipeline flush
  output logic                 flush,
  output logic [31:0]          flush_pc
);

  localparam int ROB_SIZE = 1 << ROB_WIDTH;

  typedef enum logic [1:0] {
    T_REG    = 2'd0,
    T_STORE  = 2'd1,
    T_BRANCH = 2'd2,
    T_JALR   = 2'd3
  } rob_type_t;

  // control state
  logic [ROB_SIZE-1:0]  present_q;
  logic [ROB_SIZE-1:0]  ready_q;
  logic [ROB_WIDTH-1:0] head_q;
  logic [ROB_WIDTH-1:0] tail_q;
  logic [ROB_WIDTH:0]   count_q;

  // payload
  rob_type_t            type_q  [ROB_SIZE];
  logic [4:0]           rd_q    [ROB_SIZE];
  logic [ROB_SIZE-1:0]  pred_q;
  logic [31:0]          value_q [ROB_SIZE];
  logic [31:0]          addr_q  [ROB_SIZE];

  logic      issue;
  logic      commit;
  logic      rs_go;
  logic      lsb_go;
  rob_type_t head_type;
  logic      mispredict;
  logic      flush_start;

  // Decode this cycle's issue, completion and retirement events.
  always_comb begin
    dec_full    = (count_q == (ROB_WIDTH + 1)'(ROB_SIZE));
    dec_rob_id  = tail_q;
    issue       = dec_rdy && !flush && !dec_full;
    rs_go       = rs_rdy && !flush;
    lsb_go      = lsb_rdy && !flush;
    commit      = !flush && present_q[head_q] && ready_q[head_q];
    head_type   = type_q[head_q];
    mispredict  = (head_type == T_BRANCH) && (value_q[head_q][0] != pred_q[head_q]);
    flush_start = commit && (mispredict || (head_type == T_JALR));
  end

  // Operand lookups read stored state only; same-cycle completions are not forwarded.
  always_comb begin
    query_ready_j = ready_q[query_id_j];
    query_ready_k = ready_q[query_id_k];
    query_data_j  = value_q[query_id_j];
    query_data_k  = value_q[query_id_k];
  end

  // Pointers, occupancy and per-slot present/ready flags.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      present_q <= '0;
      ready_q   <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
    end else if (rdy_in) begin
      if (issue) begin
        present_q[tail_q] <= 1'b1;
        ready_q[tail_q]   <= 1'b0;
        tail_q            <= tail_q + ROB_WIDTH'(1);
      end
      if (lsb_go) ready_q[lsb_rob_id] <= 1'b1;
      if (rs_go)  ready_q[rs_rob_id]  <= 1'b1;
      if (commit) begin
        present_q[head_q] <= 1'b0;
        head_q            <= head_q + ROB_WIDTH'(1);
      end
      count_q <= count_q + (ROB_WIDTH + 1)'(issue) - (ROB_WIDTH + 1)'(commit);
      // A redirecting retirement abandons everything younger, including a
      // same-cycle issue; ready flags are left for queries to observe.
      if (flush_start) begin
        present_q <= '0;
        head_q    <= '0;
        tail_q    <= '0;
        count_q   <= '0;
      end
    end
  end

  // Entry payload: written at issue, then overwritten by completions (RS last so it wins).
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pred_q <= '0;
      for (int i = 0; i < ROB_SIZE; i++) begin
        type_q[i]  <= T_REG;
        rd_q[i]    <= '0;
        value_q[i] <= '0;
        addr_q[i]  <= '0;
      end
    end else if (rdy_in) begin
      if (issue) begin
        type_q[tail_q]  <= rob_type_t'(dec_type);
        rd_q[tail_q]    <= dec_rd;
        pred_q[tail_q]  <= dec_pred_jump;
        value_q[tail_q] <= dec_value;
        addr_q[tail_q]  <= dec_alt_pc;
      end
      if (lsb_go) value_q[lsb_rob_id] <= lsb_data;
      if (rs_go) begin
        if (rs_set_jump_addr) addr_q[rs_rob_id]  <= rs_data;
        else                  value_q[rs_rob_id] <= rs_data;
      end
    end
  end

  // Registered commit outputs; enables and flush are single-cycle pulses.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      reg_en            <= 1'b0;
      reg_rd            <= '0;
      reg_rob_id        <= '0;
      reg_data          <= '0;
      lsb_commit_en     <= 1'b0;
      lsb_commit_rob_id <= '0;
      flush             <= 1'b0;
      flush_pc          <= '0;
    end else if (rdy_in) begin
      reg_en        <= 1'b0;
      lsb_commit_en <= 1'b0;
      flush         <= 1'b0;
      if (commit) begin
        case (head_type)
          T_REG: begin
            reg_en     <= 1'b1;
            reg_rd     <= rd_q[head_q];
            reg_rob_id <= head_q;
            reg_data   <= value_q[head_q];
          end
          T_STORE: begin
            lsb_commit_en     <= 1'b1;
            lsb_commit_rob_id <= head_q;
          end
          T_BRANCH: begin
            if (mispredict) begin
              flush    <= 1'b1;
              flush_pc <= addr_q[head_q];
            end
          end
          T_JALR: begin
            reg_en     <= 1'b1;
            reg_rd     <= rd_q[head_q];
            reg_rob_id <= head_q;
            reg_data   <= value_q[head_q];
            flush      <= 1'b1;
            flush_pc   <= addr_q[head_q];
          end
          default: ;
        endcase
      end
    end
  end

endmodule
